// File: rtl/ftq_update_gen.sv
// ftq_update_gen: consumer end of the fetch target queue.
// Resolved branches are matched against the FTQ head entry. A match pops the
// head and produces a registered BHT update with the new saturating-counter value.
// A PC mismatch, or a resolution arriving while the queue is empty, raises a
// desync. The block then requests an FTQ flush and ignores resolutions until
// the pipeline flush arrives.
module ftq_update_gen #(
  parameter int VLEN   = 64,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              res_valid_i,
  input  logic [VLEN-1:0]   res_pc_i,
  input  logic              res_taken_i,
  input  logic              res_mispredict_i,
  input  logic              ftq_empty_i,
  input  logic [VLEN-1:0]   ftq_pc_i,
  input  logic [CNT_W-1:0]  ftq_cnt_i,
  output logic              ftq_pop_o,
  output logic              flush_ftq_o,
  output logic              desync_o,
  output logic              bht_update_valid_o,
  output logic [VLEN-1:0]   bht_update_pc_o,
  output logic              bht_update_taken_o,
  output logic [CNT_W-1:0]  bht_update_cnt_o,
  output logic [PERF_W-1:0] update_cnt_o,
  output logic [PERF_W-1:0] mispredict_cnt_o
);

  typedef enum logic {RUN, RESYNC} state_t;

  // Counter arithmetic is one bit wider than the counter, so the clamp can
  // detect overflow and underflow before the result is truncated.
  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  state_t           state;
  logic             pc_match;
  logic             accept;
  logic             desync_evt;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   cnt_dec;
  logic [CNT_W-1:0] cnt_new;

  // A resolution is either accepted (it matches the head) or causes a desync.
  // A flush cycle, or the RESYNC state, suppresses both.
  always_comb begin
    pc_match   = (res_pc_i == ftq_pc_i);
    accept     = (state == RUN) & res_valid_i & ~flush_i & ~ftq_empty_i & pc_match;
    desync_evt = (state == RUN) & res_valid_i & ~flush_i & (ftq_empty_i | ~pc_match);
    ftq_pop_o  = accept;
  end

  // Saturating increment or decrement of the head entry's counter snapshot.
  always_comb begin
    cnt_ext = {1'b0, ftq_cnt_i};
    cnt_inc = cnt_ext + CNT_ONE;
    if (cnt_inc > CNT_MAX) begin
      cnt_inc = CNT_MAX;
    end
    // Decrementing from zero wraps, which sets the extra top bit.
    cnt_dec = cnt_ext - CNT_ONE;
    if (cnt_dec[CNT_W]) begin
      cnt_dec = '0;
    end
    cnt_new = res_taken_i ? cnt_inc[CNT_W-1:0] : cnt_dec[CNT_W-1:0];
  end

  // State machine, registered update outputs, one-cycle pulses and perf counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= RUN;
      flush_ftq_o        <= 1'b0;
      desync_o           <= 1'b0;
      bht_update_valid_o <= 1'b0;
      bht_update_pc_o    <= '0;
      bht_update_taken_o <= 1'b0;
      bht_update_cnt_o   <= '0;
      update_cnt_o       <= '0;
      mispredict_cnt_o   <= '0;
    end else begin
      flush_ftq_o        <= 1'b0;
      desync_o           <= 1'b0;
      bht_update_valid_o <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            bht_update_valid_o <= 1'b1;
            bht_update_pc_o    <= res_pc_i;
            bht_update_taken_o <= res_taken_i;
            bht_update_cnt_o   <= cnt_new;
            update_cnt_o       <= update_cnt_o + PERF_W'(1);
            mispredict_cnt_o   <= mispredict_cnt_o + PERF_W'(res_mispredict_i);
          end else if (desync_evt) begin
            desync_o    <= 1'b1;
            flush_ftq_o <= 1'b1;
            state       <= RESYNC;
          end
        end
        RESYNC: begin
          // Resolutions are ignored here. Only the pipeline flush ends the
          // resync.
          if (flush_i) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ftq_update_gen.sv
// Testbench for ftq_update_gen: directed scenarios followed by random traffic,
// all checked against a behavioural model of the FTQ consumer.
module tb_ftq_update_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        res_valid_i;
  logic [63:0] res_pc_i;
  logic        res_taken_i;
  logic        res_mispredict_i;
  logic        ftq_empty_i;
  logic [63:0] ftq_pc_i;
  logic [1:0]  ftq_cnt_i;
  logic        ftq_pop_o;
  logic        flush_ftq_o;
  logic        desync_o;
  logic        bht_update_valid_o;
  logic [63:0] bht_update_pc_o;
  logic        bht_update_taken_o;
  logic [1:0]  bht_update_cnt_o;
  logic [31:0] update_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  bit          m_resync;
  bit          m_valid;
  logic [63:0] m_pc;
  bit          m_taken;
  int          m_cnt;
  bit          m_desync;
  logic [31:0] m_upd;
  logic [31:0] m_mis;

  ftq_update_gen #(.VLEN(64), .CNT_W(2), .PERF_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i), .ftq_empty_i(ftq_empty_i),
    .ftq_pc_i(ftq_pc_i), .ftq_cnt_i(ftq_cnt_i), .ftq_pop_o(ftq_pop_o),
    .flush_ftq_o(flush_ftq_o), .desync_o(desync_o),
    .bht_update_valid_o(bht_update_valid_o), .bht_update_pc_o(bht_update_pc_o),
    .bht_update_taken_o(bht_update_taken_o), .bht_update_cnt_o(bht_update_cnt_o),
    .update_cnt_o(update_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".valid"},  64'(bht_update_valid_o), 64'(m_valid));
    chk({tag, ".pc"},     bht_update_pc_o, m_pc);
    chk({tag, ".taken"},  64'(bht_update_taken_o), 64'(m_taken));
    chk({tag, ".cnt"},    64'(bht_update_cnt_o), 64'(m_cnt));
    chk({tag, ".desync"}, 64'(desync_o), 64'(m_desync));
    chk({tag, ".flush"},  64'(flush_ftq_o), 64'(m_desync));
    chk({tag, ".upd"},    64'(update_cnt_o), 64'(m_upd));
    chk({tag, ".mis"},    64'(mispredict_cnt_o), 64'(m_mis));
  endtask

  // Asynchronous reset. The outputs are checked while reset is still held.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; res_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    m_resync = 0; m_valid = 0; m_pc = '0; m_taken = 0; m_cnt = 0;
    m_desync = 0; m_upd = '0; m_mis = '0;
    chk_regs("reset");
    chk("reset.pop", 64'(ftq_pop_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Runs one clock cycle of stimulus. The combinational pop is checked before
  // the edge, and the registered outputs after it.
  task automatic cyc(input string tag, input bit v, input logic [63:0] pc,
                     input bit tk, input bit mp, input bit fl, input bit emp,
                     input logic [63:0] fpc, input int fcnt);
    bit acc;
    int nc;
    @(negedge clk_i);
    res_valid_i = v; res_pc_i = pc; res_taken_i = tk; res_mispredict_i = mp;
    flush_i = fl; ftq_empty_i = emp; ftq_pc_i = fpc; ftq_cnt_i = 2'(fcnt);
    #1;
    acc = !m_resync && v && !fl && !emp && (pc == fpc);
    chk({tag, ".pop"}, 64'(ftq_pop_o), 64'(acc));
    @(posedge clk_i);
    m_valid  = 0;
    m_desync = 0;
    if (m_resync) begin
      if (fl) m_resync = 0;
    end else if (acc) begin
      nc = tk ? fcnt + 1 : fcnt - 1;
      if (nc > 3) nc = 3;
      if (nc < 0) nc = 0;
      m_valid = 1; m_pc = pc; m_taken = tk; m_cnt = nc;
      m_upd = m_upd + 1;
      if (mp) m_mis = m_mis + 1;
    end else if (v && !fl) begin
      m_desync = 1;
      m_resync = 1;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] fpc;
    logic [31:0] base;
    rst_i = 1'b0; flush_i = 1'b0; res_valid_i = 1'b0; res_pc_i = '0;
    res_taken_i = 1'b0; res_mispredict_i = 1'b0; ftq_empty_i = 1'b1;
    ftq_pc_i = '0; ftq_cnt_i = '0;

    do_reset();

    // Build up a count, enter RESYNC, then reset while still resyncing.
    cyc("pre", 1, 64'h40, 1, 0, 0, 0, 64'h40, 2);
    cyc("enter_resync", 1, 64'h100, 0, 0, 0, 0, 64'h104, 1);
    do_reset();
    idle("post_reset");
    chk("post_reset.upd0", 64'(update_cnt_o), 64'd0);

    // Matching resolution: the counter goes from 1 to 2.
    cyc("match", 1, 64'h8000_0040, 1, 0, 0, 0, 64'h8000_0040, 1);
    chk("match.cnt2", 64'(bht_update_cnt_o), 64'd2);
    chk("match.upd1", 64'(update_cnt_o), 64'd1);

    // Saturation at the top and at zero, plus a mispredict.
    cyc("sat_hi", 1, 64'h200, 1, 0, 0, 0, 64'h200, 3);
    chk("sat_hi.cnt3", 64'(bht_update_cnt_o), 64'd3);
    cyc("sat_lo", 1, 64'h204, 0, 0, 0, 0, 64'h204, 0);
    chk("sat_lo.cnt0", 64'(bht_update_cnt_o), 64'd0);
    cyc("mispred", 1, 64'h208, 0, 1, 0, 0, 64'h208, 2);
    chk("mispred.mis1", 64'(mispredict_cnt_o), 64'd1);

    // Mismatch: desync, three matching resolutions dropped, then flush and recover.
    cyc("mismatch", 1, 64'h100, 1, 0, 0, 0, 64'h104, 1);
    for (int i = 0; i < 3; i++)
      cyc("dropped", 1, 64'h300, 1, 1, 0, 0, 64'h300, 1);
    cyc("flush_exit", 1, 64'h300, 1, 0, 1, 0, 64'h300, 1);
    cyc("recover", 1, 64'h300, 1, 0, 0, 0, 64'h300, 1);

    // Empty FTQ takes the desync path.
    cyc("empty", 1, 64'h400, 1, 0, 0, 1, 64'h400, 1);
    cyc("empty_flush", 0, 64'h0, 0, 0, 1, 1, 64'h0, 0);

    // Four back-to-back matches, with flush in the third cycle.
    base = m_upd;
    for (int i = 0; i < 4; i++) begin
      pc = 64'h1000 + 64'(i * 4);
      cyc("b2b", 1, pc, i[0], 0, (i == 2), 0, pc, i % 4);
    end
    chk("b2b.upd_plus3", 64'(update_cnt_o), 64'(base + 32'd3));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pc  = {$urandom, $urandom};
      fpc = ($urandom_range(99) < 6) ? (pc ^ (64'd1 << $urandom_range(63))) : pc;
      cyc("rand", ($urandom_range(99) < 80), pc, 1'($urandom), 1'($urandom),
          ($urandom_range(99) < 8), ($urandom_range(99) < 4), fpc,
          int'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
